// File: rtl/conv3x3_tmux_core.sv
// -----------------------------------------------------------------------------
// conv3x3_tmux_core
//
// Time-multiplexed 3x3 convolution core. One CH_IN x 3 x 3 window is accepted
// and then one output channel is computed per cycle (all CH_IN*9 taps in
// parallel). Each lane is requantised with an arithmetic right shift, an
// optional ReLU and saturation to a signed byte. After CH_OUT cycles the full
// output vector is presented and held until consumed.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     window present
//   in_ready     window accepted when in_valid && in_ready (IDLE, no write)
//   in_win       CH_IN*9 bytes, byte (ic*9 + row*3 + col) at [(idx)*8 +: 8]
//   quant_shift  arithmetic right-shift amount applied to the accumulator
//   act_mode     0 = identity, 1 = ReLU
//   wr_en        coefficient write strobe (honoured only in IDLE)
//   wr_addr      < NW: weight index, NW..NW+CH_OUT-1: bias index
//   wr_data      weight in [7:0] (signed) or 16-bit signed bias
//   out_valid    result vector present
//   out_ready    result consumed when out_valid && out_ready
//   out_data     signed byte for output channel oc at [oc*8 +: 8]
//   busy         high while a window is being computed or held
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module conv3x3_tmux_core #(
    parameter int CH_IN        = 8,
    parameter int CH_OUT       = 16,
    parameter int INPUT_SIGNED = 0,
    parameter int ACC_W        = 32,
    localparam int NW          = CH_OUT * CH_IN * 9,
    localparam int ADDR_W      = $clog2(NW + CH_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_IN*9*8-1:0]    in_win,
    input  logic [4:0]              quant_shift,
    input  logic                    act_mode,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [15:0]             wr_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_OUT*8-1:0]     out_data,
    output logic                    busy
);

    localparam int NTAP = CH_IN * 9;
    localparam int OC_W = (CH_OUT > 1) ? $clog2(CH_OUT) : 1;

    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                     state_q;
    logic [OC_W-1:0]            oc_q;
    logic                       out_valid_q;
    logic                       busy_q;
    logic [CH_OUT*8-1:0]        out_data_q;
    logic [NTAP*8-1:0]          win_q;
    logic [4:0]                 shift_q;
    logic                       mode_q;

    logic signed [7:0]          w_q    [NW];
    logic signed [15:0]         bias_q [CH_OUT];

    logic                       wr_ok;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    q_d;
    logic signed [8:0]          pix_d;
    logic [ADDR_W-1:0]          widx_d;
    logic [7:0]                 lane_d;

    // NOTE: in_ready looks at wr_en combinationally so that a coefficient
    // write wins over a window offered in the same cycle.
    assign wr_ok     = wr_en && (state_q == IDLE);
    assign in_ready  = (state_q == IDLE) && !wr_en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

    // -------------------------------------------------------------------------
    // Coefficient storage
    // -------------------------------------------------------------------------
    // NOTE: the coefficient arrays are cleared by reset on purpose; a reset
    // must leave an all-zero filter, so this storage cannot map to a plain RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) begin
                w_q[i] <= '0;
            end
            for (int o = 0; o < CH_OUT; o++) begin
                bias_q[o] <= '0;
            end
        end else if (wr_ok) begin
            if ({1'b0, wr_addr} < (ADDR_W+1)'(NW)) begin
                w_q[wr_addr] <= wr_data[7:0];
            end
            // Addresses past the bias range match nothing and are dropped.
            for (int o = 0; o < CH_OUT; o++) begin
                if ({1'b0, wr_addr} == (ADDR_W+1)'(NW + o)) begin
                    bias_q[o] <= wr_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath for the current output channel oc_q
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d  = ACC_W'(bias_q[oc_q]);
        pix_d  = '0;
        widx_d = '0;
        for (int t = 0; t < NTAP; t++) begin
            // Unsigned pixels get a zero ninth bit so the multiply stays signed.
            if (INPUT_SIGNED != 0) begin
                pix_d = {win_q[t*8+7], win_q[t*8 +: 8]};
            end else begin
                pix_d = {1'b0, win_q[t*8 +: 8]};
            end
            widx_d = ADDR_W'(int'(oc_q) * NTAP + t);
            acc_d  = acc_d + ACC_W'(pix_d) * ACC_W'(w_q[widx_d]);
        end

        // Arithmetic shift rounds toward minus infinity.
        q_d = acc_d >>> shift_q;
        if (mode_q && q_d[ACC_W-1]) begin
            q_d = '0;
        end

        if (q_d > Q_MAX) begin
            lane_d = 8'h7F;
        end else if (q_d < Q_MIN) begin
            lane_d = 8'h80;
        end else begin
            lane_d = q_d[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            oc_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            win_q       <= '0;
            shift_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        win_q   <= in_win;
                        shift_q <= quant_shift;
                        mode_q  <= act_mode;
                        oc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int o = 0; o < CH_OUT; o++) begin
                        if (oc_q == OC_W'(o)) begin
                            out_data_q[o*8 +: 8] <= lane_d;
                        end
                    end
                    if (oc_q == OC_W'(CH_OUT - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        oc_q <= oc_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        oc_q        <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_tmux_core.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_tmux_core
//
// Self-checking bench for conv3x3_tmux_core. A default-parameter instance
// covers unsigned windows, saturation, ReLU, bias, write gating, DONE hold
// and reset mid-compute; a signed single-input-channel instance covers floor
// shifting of negative accumulators and per-lane weight selection.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_conv3x3_tmux_core;

    localparam int CH_IN    = 8;
    localparam int CH_OUT   = 16;
    localparam int NW       = CH_OUT * CH_IN * 9;
    localparam int ADDR_W   = $clog2(NW + CH_OUT);
    localparam int S_CH_IN  = 1;
    localparam int S_NW     = CH_OUT * S_CH_IN * 9;
    localparam int S_ADDR_W = $clog2(S_NW + CH_OUT);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default instance
    logic                   in_valid, in_ready, act_mode, wr_en;
    logic [CH_IN*72-1:0]    in_win;
    logic [4:0]             quant_shift;
    logic [ADDR_W-1:0]      wr_addr;
    logic [15:0]            wr_data;
    logic                   out_valid, out_ready, busy;
    logic [CH_OUT*8-1:0]    out_data;

    // signed, single-input-channel instance
    logic                   s_in_valid, s_in_ready, s_act_mode, s_wr_en;
    logic [S_CH_IN*72-1:0]  s_in_win;
    logic [4:0]             s_quant_shift;
    logic [S_ADDR_W-1:0]    s_wr_addr;
    logic [15:0]            s_wr_data;
    logic                   s_out_valid, s_out_ready, s_busy;
    logic [CH_OUT*8-1:0]    s_out_data;

    conv3x3_tmux_core #(
        .CH_IN(CH_IN), .CH_OUT(CH_OUT), .INPUT_SIGNED(0), .ACC_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
        .quant_shift(quant_shift), .act_mode(act_mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    conv3x3_tmux_core #(
        .CH_IN(S_CH_IN), .CH_OUT(CH_OUT), .INPUT_SIGNED(1), .ACC_W(32)
    ) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_win(s_in_win),
        .quant_shift(s_quant_shift), .act_mode(s_act_mode),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .busy(s_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] pix;
        logic [4:0] sh;
        logic       md;
        logic [7:0] lane;
    } vec_t;

    vec_t tbl [7];

    int           lat;
    logic [127:0] res;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH_IN*72-1:0] win_of(input logic [7:0] b);
        return {(CH_IN*9){b}};
    endfunction

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {CH_OUT{b}};
    endfunction

    task automatic wr(input int addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic s_wr(input int addr, input logic [15:0] data);
        s_wr_en   = 1'b1;
        s_wr_addr = S_ADDR_W'(addr);
        s_wr_data = data;
        tick();
        s_wr_en   = 1'b0;
    endtask

    // Offer a window, count cycles from the accept edge to out_valid,
    // capture the result and consume it.
    task automatic run_win(input logic [CH_IN*72-1:0] win, input logic [4:0] sh,
                           input logic md, output int l, output logic [127:0] r);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        in_win = win; quant_shift = sh; act_mode = md; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 100) begin
            tick();
            l++;
        end
        r = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic s_run(input logic [S_CH_IN*72-1:0] win, input logic [4:0] sh,
                         input logic md, output int l, output logic [127:0] r);
        int guard = 0;
        while (!s_in_ready && guard < 100) begin
            tick();
            guard++;
        end
        s_in_win = win; s_quant_shift = sh; s_act_mode = md; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        l = 0;
        while (!s_out_valid && l < 100) begin
            tick();
            l++;
        end
        r = s_out_data;
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_v;
        logic         seen;

        // uniform window pixel, shift, mode -> every lane (all weights 1, bias 0)
        tbl[0] = '{8'hFF, 5'd7,  1'b0, 8'h7F};  // 18360 >>> 7 = 143, saturated
        tbl[1] = '{8'hFF, 5'd8,  1'b0, 8'h47};  // 18360 >>> 8 = 71
        tbl[2] = '{8'h01, 5'd0,  1'b0, 8'h48};  // 72
        tbl[3] = '{8'h02, 5'd0,  1'b0, 8'h7F};  // 144, saturated
        tbl[4] = '{8'h00, 5'd0,  1'b0, 8'h00};
        tbl[5] = '{8'h10, 5'd4,  1'b1, 8'h48};  // 1152 >>> 4 = 72, ReLU passes
        tbl[6] = '{8'hFF, 5'd31, 1'b0, 8'h00};

        rst = 1'b1;
        in_valid = 1'b0; in_win = '0; quant_shift = '0; act_mode = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_win = '0; s_quant_shift = '0; s_act_mode = 1'b0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_out_data",  out_data,        '0);
        check("rst_in_ready",  128'(in_ready),  128'(1));

        // A write in IDLE blocks a simultaneously offered window.
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'h0001; in_valid = 1'b1;
        in_win = win_of(8'hFF);
        #1;
        check("in_ready_low_during_write", 128'(in_ready), 128'(0));
        tick();
        wr_en = 1'b0; in_valid = 1'b0;
        check("write_wins_over_accept", 128'(busy), 128'(0));
        for (int a = 1; a < NW; a++) begin
            wr(a, 16'h0001);
        end

        // Table-driven windows
        foreach (tbl[i]) begin
            run_win(win_of(tbl[i].pix), tbl[i].sh, tbl[i].md, lat, res);
            check($sformatf("tbl%0d_latency", i), 128'(lat), 128'(16));
            check($sformatf("tbl%0d_lanes", i), res, rep(tbl[i].lane));
        end

        // Hold in DONE with out_ready low while another window is offered
        in_win = win_of(8'hFF); quant_shift = 5'd7; act_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("hold_latency", 128'(lat), 128'(16));
        in_win = win_of(8'h00); quant_shift = 5'd0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d_data", c),     out_data,         rep(8'h7F));
            check($sformatf("hold%0d_valid", c),    128'(out_valid),  128'(1));
            check($sformatf("hold%0d_in_ready", c), 128'(in_ready),   128'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 128'(out_valid), 128'(0));
        check("release_in_ready",  128'(in_ready),  128'(1));
        check("release_busy",      128'(busy),      128'(0));

        // Write during COMPUTE is ignored
        in_win = win_of(8'hFF); quant_shift = 5'd8; act_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'h0005;
        tick();
        wr_en = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("compute_write_result", out_data, rep(8'h47));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_win(win_of(8'hFF), 5'd8, 1'b0, lat, res);
        check("compute_write_ignored", res, rep(8'h47));

        // Same write in IDLE takes effect: lane0 = 76*255 >>> 8 = 75
        wr(0, 16'h0005);
        run_win(win_of(8'hFF), 5'd8, 1'b0, lat, res);
        check("idle_write_applied", res, {{(CH_OUT-1){8'h47}}, 8'h4B});

        // Reset while computing lane 7
        in_win = win_of(8'hFF); quant_shift = 5'd0; act_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("pre_rst_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_busy",     128'(busy),     128'(0));
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("post_rst_no_out_valid", 128'(seen), 128'(0));
        run_win(win_of(8'hFF), 5'd0, 1'b0, lat, res);
        check("post_rst_latency", 128'(lat), 128'(16));
        check("post_rst_cleared", res, rep(8'h00));

        // Bias only: bias[3] = -300; out-of-range address ignored
        wr(NW + 3, 16'hFED4);
        wr((1 << ADDR_W) - 1, 16'h0005);
        run_win(win_of(8'hFF), 5'd0, 1'b0, lat, res);
        exp_v = '0;
        exp_v[3*8 +: 8] = 8'h80;
        check("bias_neg_sat", res, exp_v);
        run_win(win_of(8'hFF), 5'd0, 1'b1, lat, res);
        check("bias_relu", res, '0);

        // Signed instance: -1 >>> 1 floors to -1
        for (int o = 0; o < CH_OUT; o++) begin
            s_wr(o * 9, 16'h0001);
        end
        s_run({56'h0, 8'h00, 8'hFF}, 5'd1, 1'b0, lat, res);
        check("signed_latency", 128'(lat), 128'(16));
        check("signed_floor", res, rep(8'hFF));

        // Per-lane weights on tap 1: lane oc = -1 + 2*oc
        for (int o = 0; o < CH_OUT; o++) begin
            s_wr(o * 9 + 1, 16'(o));
        end
        for (int m = 0; m < 2; m++) begin
            s_run({56'h0, 8'h02, 8'hFF}, 5'd0, m[0], lat, res);
            for (int o = 0; o < CH_OUT; o++) begin
                exp_v[o*8 +: 8] = 8'(2 * o - 1);
            end
            if (m == 1) exp_v[7:0] = 8'h00;
            check($sformatf("signed_lanes_mode%0d", m), res, exp_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_tmux_core.md
CONV3X3_TMUX_CORE -- requirements
Module: conv3x3_tmux_core

Interface
REQ-001 SHALL have parameter CH_IN, default 8: input channels per 3x3 window.
REQ-002 SHALL have parameter CH_OUT, default 16: output channels, computed one per cycle.
REQ-003 SHALL have parameter INPUT_SIGNED, default 0: 1 means window bytes are signed, 0 means unsigned.
REQ-004 SHALL have parameter ACC_W, default 32: signed accumulator width.
REQ-005 SHALL derive localparam NW = CH_OUT*CH_IN*9 and ADDR_W = clog2(NW+CH_OUT).
REQ-006 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1: window present.
REQ-009 SHALL have port in_ready, output, 1: window accepted when in_valid && in_ready.
REQ-010 SHALL have port in_win, input, CH_IN*9*8: byte (ic*9+k) at bits [(ic*9+k)*8 +: 8], with k = row*3+col.
REQ-011 SHALL have port quant_shift, input, 5: arithmetic right-shift amount.
REQ-012 SHALL have port act_mode, input, 1: 0 = identity, 1 = ReLU.
REQ-013 SHALL have port wr_en, input, 1: coefficient write strobe.
REQ-014 SHALL have port wr_addr, input, ADDR_W: coefficient address.
REQ-015 SHALL have port wr_data, input, 16: coefficient data.
REQ-016 SHALL have port out_valid, output, 1: result present.
REQ-017 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-018 SHALL have port out_data, output, CH_OUT*8: signed byte for oc at bits [oc*8 +: 8].
REQ-019 SHALL have port busy, output, 1: high in COMPUTE or DONE.

Function
REQ-020 SHALL implement FSM states IDLE, COMPUTE and DONE; in_ready = (state==IDLE) && !wr_en.
REQ-021 On accept in IDLE: SHALL register in_win, quant_shift and act_mode, clear oc counter to 0, and enter COMPUTE.
REQ-022 Each COMPUTE cycle SHALL write lane oc: acc = bias[oc] (sign-extended) + sum over ic,k of win[ic*9+k]*w[(oc*CH_IN+ic)*9+k], computed in ACC_W bits.
REQ-023 Products SHALL be signed 8x8 when INPUT_SIGNED=1; otherwise the window byte SHALL be zero-extended to 9 bits before the signed multiply.
REQ-024 SHALL compute q = acc >>> quant_shift (floor); if act_mode=1 and q<0 then q=0; then saturate q to [-128,127].
REQ-025 When oc==CH_OUT-1, SHALL move to DONE; otherwise oc SHALL increment. out_valid SHALL rise exactly CH_OUT cycles after the accept edge.
REQ-026 In DONE, out_valid=1 and out_data SHALL hold stable until out_ready; on handshake, SHALL return to IDLE, and in_ready SHALL rise on the next cycle.
REQ-027 Minimum window period SHALL be CH_OUT+2 cycles; no input is accepted while busy.
REQ-028 A coefficient write SHALL take effect only when wr_en is high in IDLE; it SHALL take priority over input acceptance that cycle; writes in COMPUTE or DONE SHALL be ignored.
REQ-029 For wr_addr < NW, SHALL set w[wr_addr] = wr_data[7:0] (signed).
REQ-030 For NW <= wr_addr < NW+CH_OUT, SHALL set bias[wr_addr-NW] = wr_data (signed 16-bit).
REQ-031 Higher wr_addr values SHALL be ignored.
REQ-032 out_data lanes not yet written in the current window SHALL be unobservable (out_valid=0).

Reset
REQ-033 On rst high at a clock edge, SHALL set: state = IDLE, oc = 0, out_valid = 0, out_data = 0, busy = 0, all weights and biases = 0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts (if wr_en=0).
REQ-035 Reset mid-COMPUTE or mid-DONE SHALL discard the window and produce no out_valid.

Verification
REQ-036 Defaults, all w=1, bias=0, window all 0xFF, shift=7, mode=0 -> sum 18360, q=143, every lane 0x7F, out_valid 16 cycles after accept.
REQ-037 All w=0, bias[3]=-300, shift=0 -> lane3 = 0x80 with mode=0 and 0x00 with mode=1; other lanes 0x00.
REQ-038 INPUT_SIGNED=1, CH_IN=1, w[(oc*CH_IN)*9+0]=1 for all oc, window byte0=0xFF, shift=1 -> acc=-1, q=-1, lane 0xFF (floor, not truncate toward zero).
REQ-039 Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-040 wr_en pulse (addr 0, data 0x05) during COMPUTE -> w[0] unchanged, current result unaffected; same write in IDLE -> in_ready=0 that cycle and w[0]=5 afterwards.
REQ-041 rst asserted at COMPUTE oc=7 -> out_valid never rises, in_ready=1 after release, all-ones window yields 0x00 in every lane (coefficients cleared).
